regfile_pipe: RTL and testbench
===============================

REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port we  input  1  write enable.
REQ-007 Port waddr  input  ADDR_W  write register index.
REQ-008 Port wdata  input  DATA_W  write data.
REQ-009 Port raddr1, raddr2  input  ADDR_W each  read indices.
REQ-010 Port rdata1, rdata2  output  DATA_W each  combinational read data.
REQ-011 Port rsv_valid  input  1  reserve the destination register for a pending write.
REQ-012 Port rsv_addr  input  ADDR_W  register index to reserve.
REQ-013 Port busy1, busy2  output  1 each  pending-write flag for raddr1 / raddr2.
REQ-014 Port clr_req  input  1  request a full-array clear sweep.
REQ-015 Port clr_busy  output  1  clear sweep in progress.

Function
REQ-016 On a rising edge with we=1 in IDLE, the block SHALL store wdata at waddr (except index 0 when ZERO_REG=1).
REQ-017 rdataN SHALL be the contents of raddrN with zero latency; it SHALL be 0 when ZERO_REG=1 and raddrN=0, and 0 while clr_busy=1.
REQ-018 The scoreboard SHALL hold one pending bit per register; rsv_valid=1 in IDLE sets pending[rsv_addr]; we=1 in IDLE clears pending[waddr].
REQ-019 If a reservation and a write target the same index in the same cycle, the set SHALL win (pending stays 1).
REQ-020 busyN SHALL equal pending[raddrN]; it SHALL be 0 for index 0 when ZERO_REG=1.
REQ-021 The clear FSM SHALL have states IDLE and CLEAR; clr_req=1 in IDLE moves to CLEAR on the next edge and clears all pending bits on that edge.
REQ-022 In CLEAR, a ADDR_W-bit counter starting at 0 SHALL zero one register per cycle; after index DEPTH-1 is zeroed, the FSM returns to IDLE, giving exactly DEPTH cycles with clr_busy=1.
REQ-023 In CLEAR, we, rsv_valid and clr_req SHALL be ignored; busy1/busy2 SHALL be 0.
REQ-024 clr_busy SHALL be 1 exactly when the FSM is in CLEAR.

Reset
REQ-025 rst_n=0 SHALL asynchronously zero all registers, all pending bits and the sweep counter, and force IDLE.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep; after release, clr_busy=0, rdataN=0 and busyN=0 for all indices.

Configuration
REQ-027 With macro RF_BYPASS_EN defined, rdataN SHALL return wdata when we=1, state is IDLE, waddr=raddrN and the index is writable, and busyN SHALL be 0 in that case.
REQ-028 Without RF_BYPASS_EN, reads SHALL return only stored contents and busyN SHALL equal pending[raddrN] irrespective of a same-cycle write.

Structure
REQ-029 Package rf_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-030 The pending-bit array, its set/clear priority and the busy lookups SHALL be the sub-module rf_scoreboard.

Verification
REQ-031 Reset, then we=1 waddr=3 wdata=0xDEADBEEF, next cycle raddr1=3 -> rdata1=0xDEADBEEF; raddr2=0 -> rdata2=0.
REQ-032 we=1 waddr=0 wdata=0x12345678 with ZERO_REG=1 -> raddr1=0 reads 0; rsv_valid=1 rsv_addr=0 -> busy1=0.
REQ-033 rsv_valid=1 rsv_addr=7, then raddr1=7 -> busy1=1; we=1 waddr=7 wdata=0x55 -> next cycle busy1=0, rdata1=0x55; with RF_BYPASS_EN, rdata1=0x55 and busy1=0 in the write cycle itself.
REQ-034 Same-cycle rsv_valid=1 rsv_addr=9 and we=1 waddr=9 with pending[9]=1 -> pending[9] remains 1, register 9 holds the written value.
REQ-035 Fill registers 1..31 with index value, pulse clr_req -> clr_busy=1 for exactly 32 cycles, writes during sweep ignored, afterwards all reads return 0 and busy flags are 0.
REQ-036 Assert rst_n=0 at sweep cycle 10 -> clr_busy drops immediately, all registers and busy flags 0 after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the pending-write register file.
//   RF_DATA_W / RF_ADDR_W : default register width and index width
//   rf_state_e            : clear-sweep FSM states (IDLE, CLEAR)
//   rf_writable           : a register index may be written or reserved
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    // Register 0 is hardwired when the zero-register option is on.
    function automatic logic rf_writable(input logic is_index0, input logic zero_reg);
        return !(zero_reg && is_index0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one pending bit per register.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   set_en, set_addr    : reserve a register (set pending)
//   clr_en, clr_addr    : write completes (clear pending)
//   clr_all             : drop every pending bit
//   lookup_en           : gates the busy lookups (low during a sweep)
//   raddr1, raddr2      : lookup indices
//   busy1_c, busy2_c    : combinational pending flags for the lookups
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              clr_all,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1_c,
    output logic              busy2_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Set is applied after clear so a same-index reservation wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_all) begin
            pending_nxt = '0;
        end else begin
            if (clr_en) pending_nxt[clr_addr] = 1'b0;
            if (set_en) pending_nxt[set_addr] = 1'b1;
        end
        if (ZERO_REG) pending_nxt[0] = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Index 0 never holds a pending bit when hardwired, so no extra mask needed.
    assign busy1_c = lookup_en && pending[raddr1];
    assign busy2_c = lookup_en && pending[raddr2];

endmodule

// File: rtl/regfile_pipe.sv
// Register file with pending-write scoreboard and a one-register-per-cycle
// clear sweep.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   we, waddr, wdata        : write port (accepted in IDLE only)
//   raddr1/2, rdata1/2      : combinational read ports
//   rsv_valid, rsv_addr     : reserve a destination register
//   busy1, busy2            : pending-write flags for raddr1 / raddr2
//   clr_req, clr_busy       : start a full clear sweep / sweep in progress
// Build option: define RF_BYPASS_EN to forward same-cycle write data to the
// read ports and mask busy for the register being written.
module regfile_pipe
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic idle;
    logic wr_ok;
    logic rsv_ok;
    logic clr_start;
    logic sweep_last;
    logic byp1;
    logic byp2;
    logic sb_busy1;
    logic sb_busy2;

    assign idle       = (state == IDLE);
    assign wr_ok      = idle && we && rf_writable(waddr == '0, ZERO_REG);
    assign rsv_ok     = idle && rsv_valid && rf_writable(rsv_addr == '0, ZERO_REG);
    assign clr_start  = idle && clr_req;
    assign sweep_last = (cnt == ADDR_W'(DEPTH - 1));
    assign clr_busy   = (state == CLEAR);

    // Sweep FSM: next state and counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (sweep_last) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Register array: sweep zeroing takes over the write port in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle write forwarding match.
`ifdef RF_BYPASS_EN
    assign byp1 = wr_ok && (waddr == raddr1);
    assign byp2 = wr_ok && (waddr == raddr2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Read port 1.
    always_comb begin
        rdata1 = mem[raddr1];
        if (byp1) rdata1 = wdata;
        if (ZERO_REG && (raddr1 == '0)) rdata1 = '0;
        if (!idle) rdata1 = '0;
    end

    // Read port 2.
    always_comb begin
        rdata2 = mem[raddr2];
        if (byp2) rdata2 = wdata;
        if (ZERO_REG && (raddr2 == '0)) rdata2 = '0;
        if (!idle) rdata2 = '0;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (rsv_ok),
        .set_addr  (rsv_addr),
        .clr_en    (wr_ok),
        .clr_addr  (waddr),
        .clr_all   (clr_start),
        .lookup_en (idle),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1_c   (sb_busy1),
        .busy2_c   (sb_busy2)
    );

    // A register being written this cycle is not busy when forwarded.
    assign busy1 = sb_busy1 && !byp1;
    assign busy2 = sb_busy2 && !byp2;

endmodule

// File: tb/tb_regfile_pipe.sv
// Self-checking bench for regfile_pipe (default parameters).
// Driver applies inputs on the falling edge and queues the expected
// combinational outputs from a behavioural model; a monitor compares them.
module tb_regfile_pipe;

    localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        busy1;
    logic        busy2;
    logic        clr_req;
    logic        clr_busy;

    regfile_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy1     (busy1),
        .busy2     (busy2),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        b1;
        logic        b2;
        logic        cb;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Behavioural model
    logic [31:0] mem_m [DEPTH];
    bit   [31:0] pend_m;
    bit          in_clear;
    int          clr_idx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        pend_m   = '0;
        in_clear = 1'b0;
        clr_idx  = 0;
    endtask

    function automatic logic [31:0] exp_rd(input int ra, input bit w, input int wa, input logic [31:0] wd);
        if (in_clear || ra == 0) return 32'h0;
        if (BYP && w && wa == ra) return wd;
        return mem_m[ra];
    endfunction

    function automatic logic exp_busy(input int ra, input bit w, input int wa);
        if (in_clear || ra == 0) return 1'b0;
        if (BYP && w && wa == ra) return 1'b0;
        return pend_m[ra];
    endfunction

    // One cycle of stimulus: drive, queue expectation, advance model.
    task automatic step(input bit w, input int wa, input logic [31:0] wd,
                        input int ra1, input int ra2,
                        input bit rv, input int rsa, input bit cr);
        exp_t e;
        @(negedge clk);
        we        = w;
        waddr     = 5'(wa);
        wdata     = wd;
        raddr1    = 5'(ra1);
        raddr2    = 5'(ra2);
        rsv_valid = rv;
        rsv_addr  = 5'(rsa);
        clr_req   = cr;
        e.r1 = exp_rd(ra1, w, wa, wd);
        e.r2 = exp_rd(ra2, w, wa, wd);
        e.b1 = exp_busy(ra1, w, wa);
        e.b2 = exp_busy(ra2, w, wa);
        e.cb = in_clear;
        exp_q.push_back(e);
        if (in_clear) begin
            mem_m[clr_idx] = '0;
            clr_idx++;
            if (clr_idx == DEPTH) in_clear = 1'b0;
        end else begin
            if (w && wa != 0) begin
                mem_m[wa]  = wd;
                pend_m[wa] = 1'b0;
            end
            if (rv && rsa != 0) pend_m[rsa] = 1'b1;
            if (cr) begin
                pend_m   = '0;
                in_clear = 1'b1;
                clr_idx  = 0;
            end
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, i, DEPTH - 1 - i, 0, 0, 0);
    endtask

    task automatic fill();
        for (int i = 1; i < DEPTH; i++) step(1, i, 32'(i), i, 0, 0, 0, 0);
    endtask

    task automatic rand_step(input int clr_prob);
        step($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom,
             $urandom_range(0, 15), $urandom_range(0, 31),
             $urandom_range(0, 2) == 0, $urandom_range(0, 15),
             $urandom_range(0, clr_prob) == 0);
    endtask

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata1", rdata1, e.r1);
            chk("rdata2", rdata2, e.r2);
            chk("busy1", 32'(busy1), 32'(e.b1));
            chk("busy2", 32'(busy2), 32'(e.b2));
            chk("clr_busy", 32'(clr_busy), 32'(e.cb));
        end
    end

    initial begin
        int cb_cycles;
        rst_n = 1'b0;
        we = 0; waddr = 0; wdata = 0; raddr1 = 5; raddr2 = 17;
        rsv_valid = 0; rsv_addr = 0; clr_req = 0;
        model_reset();
        #12;
        chk("reset_clr_busy", 32'(clr_busy), 32'h0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_busy1", 32'(busy1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state read-back
        read_all();

        // Basic write then read
        step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 3, 0, 0, 0, 0);

        // Hardwired register 0
        step(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reserve, observe busy, complete the write
        step(0, 0, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 7, 7, 0, 0, 0);
        step(1, 7, 32'h55, 7, 3, 0, 0, 0);
        step(0, 0, 0, 7, 7, 0, 0, 0);

        // Same-cycle reserve and write: reservation wins
        step(0, 0, 0, 0, 0, 1, 9, 0);
        step(1, 9, 32'hCAFE0009, 9, 0, 1, 9, 0);
        step(0, 0, 0, 9, 9, 0, 0, 0);

        // Randomized traffic with occasional sweeps
        for (int i = 0; i < 400; i++) rand_step(120);
        while (in_clear) rand_step(1000);

        // Full sweep with writes/reservations attempted during it
        fill();
        for (int i = 1; i < 8; i++) step(0, 0, 0, 0, 0, 1, i, 0);
        step(0, 0, 0, 1, 2, 0, 0, 1);
        cb_cycles = 0;
        while (in_clear && cb_cycles < 100) begin
            cb_cycles++;
            rand_step(3);
        end
        chk("sweep_length", 32'(cb_cycles), 32'(DEPTH));
        read_all();

        // Reset during a sweep
        fill();
        step(0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) rand_step(3);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        we = 0; rsv_valid = 0; clr_req = 0;
        raddr1 = 5'd20; raddr2 = 5'd4;
        #1;
        chk("abort_clr_busy", 32'(clr_busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        read_all();
        for (int i = 0; i < 100; i++) rand_step(200);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
